// File: rtl/fetch_stage.sv
// fetch_stage: MINAv2 IF stage (PC, imem fetch, ID handoff); FETCH_MISALIGN_CHECK_EN adds fetch_misalign
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        id_valid,
  output logic [63:0] id_params
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);
  typedef struct packed {
    logic [31:0] ia_plus_4;
    logic [31:0] ir;
  } id_params_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;
  state_t     state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_inflight_q, pc_inflight_d, next_pc;
  logic       id_valid_q, id_valid_d;
  id_params_t id_params_q, id_params_d;
  always_comb begin
    next_pc        = pc_inflight_q + 32'd4;
    imem_req_valid = state_q == S_REQ && (!id_valid_q || !stall) && !redirect_valid;
    state_d        = state_q;
    pc_d           = pc_q;
    pc_inflight_d  = pc_inflight_q;
    id_params_d    = id_params_q;
    id_valid_d     = id_valid_q && stall;
    if (redirect_valid) begin
      pc_d       = redirect_addr & ~32'd3;
      id_valid_d = 1'b0;
      state_d    = state_q == S_WAIT ? (imem_rsp_valid ? S_REQ : S_DRAIN) :
                   state_q == S_IDLE ? S_REQ : state_q;
    end else if (state_q == S_IDLE) begin
      state_d = S_REQ;
    end else if (state_q == S_REQ && imem_req_valid && imem_req_ready) begin
      pc_inflight_d = pc_q;
      state_d       = S_WAIT;
    end else if (state_q == S_WAIT && imem_rsp_valid) begin
      id_params_d = '{ia_plus_4: next_pc, ir: imem_rsp_data};
      id_valid_d  = 1'b1;
      pc_d        = next_pc;
      state_d     = S_REQ;
    end else if (state_q == S_DRAIN && imem_rsp_valid) begin
      state_d = S_REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      pc_inflight_q <= '0;
      id_valid_q    <= 1'b0;
      id_params_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_inflight_q <= pc_inflight_d;
      id_valid_q    <= id_valid_d;
      id_params_q   <= id_params_d;
    end
  end
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_params = id_params_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  always_comb misalign_d = redirect_valid && redirect_addr[1:0] != 2'b00;
  always_ff @(posedge clk) misalign_q <= rst ? 1'b0 : misalign_d;
  assign fetch_misalign = misalign_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a variable-latency imem responder
module tb_fetch_stage;
  localparam logic [31:0] RV = 32'h100;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        id_valid;
  logic [63:0] id_params;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif
  int          vecs = 0, errs = 0;
  logic [63:0] sb[$];
  logic        mem_pend = 1'b0, mem_killed = 1'b0, exp_mis = 1'b0;
  int          mem_cnt = 0, lat = 1;
  logic [31:0] mem_addr = '0, exp_pc = RV;
  always #5 clk = ~clk;
  fetch_stage #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .id_valid(id_valid), .id_params(id_params)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEAD_BEEF : (a * 32'd7) ^ 32'h5A5A_C3C3;
  endfunction
  task automatic cycle();
    logic fire, cons;
    logic [31:0] fire_addr;
    imem_rsp_valid = mem_pend && mem_cnt == 0;
    imem_rsp_data  = mem_word(mem_addr);
    #1;
    fire      = imem_req_valid && imem_req_ready;
    fire_addr = imem_addr;
    cons      = id_valid && !stall;
    if (!rst) begin
      if (fire) begin
        vecs++;
        if (imem_addr !== exp_pc) begin errs++; $display("FAIL req_addr: got %h, expected %h", imem_addr, exp_pc); end
      end
      if (id_valid) begin
        vecs++;
        if (sb.size() == 0) begin errs++; $display("FAIL spurious_id_valid: got id_params %h, expected id_valid 0", id_params); end
        else if (id_params !== sb[0]) begin errs++; $display("FAIL id_params: got %h, expected %h", id_params, sb[0]); end
        if (sb.size() != 0 && (cons || redirect_valid)) void'(sb.pop_front());
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      vecs++;
      if (fetch_misalign !== exp_mis) begin errs++; $display("FAIL fetch_misalign: got %b, expected %b", fetch_misalign, exp_mis); end
`endif
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      mem_pend = 1'b0;
      exp_pc   = RV;
      exp_mis  = 1'b0;
    end else begin
      exp_mis = redirect_valid && redirect_addr[1:0] != 2'b00;
      if (imem_rsp_valid) begin
        if (!mem_killed && !redirect_valid) begin
          sb.push_back({mem_addr + 32'd4, imem_rsp_data});
          exp_pc = mem_addr + 32'd4;
        end
        mem_pend = 1'b0;
      end else if (mem_pend) begin
        mem_cnt--;
        if (redirect_valid) mem_killed = 1'b1;
      end
      if (redirect_valid) exp_pc = redirect_addr & ~32'd3;
      if (fire) begin
        mem_pend   = 1'b1;
        mem_killed = 1'b0;
        mem_cnt    = lat - 1;
        mem_addr   = fire_addr;
      end
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    #1;
    vecs += 3;
    if (id_valid !== 1'b0) begin errs++; $display("FAIL reset_id_valid: got %b, expected 0", id_valid); end
    if (id_params !== 64'h0) begin errs++; $display("FAIL reset_id_params: got %h, expected 0", id_params); end
    if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL reset_req_valid: got %b, expected 0", imem_req_valid); end
    rst = 1'b0;
    #1;
    vecs++;
    if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL idle_req_valid: got %b, expected 0", imem_req_valid); end
    cycle();
    #1;
    vecs += 2;
    if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL first_req_valid: got %b, expected 1", imem_req_valid); end
    if (imem_addr !== 32'h100) begin errs++; $display("FAIL first_req_addr: got %h, expected 00000100", imem_addr); end
  endtask
  task automatic test_basic();
    cycle();
    cycle();
    #1;
    vecs += 4;
    if (id_valid !== 1'b1) begin errs++; $display("FAIL basic_id_valid: got %b, expected 1", id_valid); end
    if (id_params !== 64'h0000_0104_DEAD_BEEF) begin errs++; $display("FAIL basic_id_params: got %h, expected 00000104deadbeef", id_params); end
    if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL basic_req_valid: got %b, expected 1", imem_req_valid); end
    if (imem_addr !== 32'h104) begin errs++; $display("FAIL basic_next_addr: got %h, expected 00000104", imem_addr); end
    cycle();
    cycle();
  endtask
  task automatic test_stall();
    logic [63:0] saved;
    saved = {32'h108, mem_word(32'h104)};
    lat = 3;
    repeat (5) begin
      stall = 1'b1;
      #1;
      vecs += 3;
      if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL stall_req_valid: got %b, expected 0", imem_req_valid); end
      if (id_valid !== 1'b1) begin errs++; $display("FAIL stall_id_valid: got %b, expected 1", id_valid); end
      if (id_params !== saved) begin errs++; $display("FAIL stall_id_params: got %h, expected %h", id_params, saved); end
      cycle();
    end
    stall = 1'b0;
    #1;
    vecs += 2;
    if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL release_req_valid: got %b, expected 1", imem_req_valid); end
    if (imem_addr !== 32'h108) begin errs++; $display("FAIL release_req_addr: got %h, expected 00000108", imem_addr); end
    cycle();
  endtask
  task automatic test_redirect_wait();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h2000;
    cycle();
    redirect_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (imem_req_valid) break;
      vecs++;
      if (id_valid !== 1'b0) begin errs++; $display("FAIL drain_id_valid: got %b, expected 0", id_valid); end
      cycle();
    end
    #1;
    vecs += 2;
    if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL drain_timeout: req_valid got %b, expected 1", imem_req_valid); end
    if (imem_addr !== 32'h2000) begin errs++; $display("FAIL drain_req_addr: got %h, expected 00002000", imem_addr); end
  endtask
  task automatic test_redirect_rsp();
    lat = 1;
    cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    #1;
    vecs += 3;
    if (id_valid !== 1'b0) begin errs++; $display("FAIL rsp_redirect_id_valid: got %b, expected 0", id_valid); end
    if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL rsp_redirect_req_valid: got %b, expected 1", imem_req_valid); end
    if (imem_addr !== 32'h40) begin errs++; $display("FAIL rsp_redirect_addr: got %h, expected 00000040", imem_addr); end
  endtask
  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    cycle();
    #1;
    vecs += 4;
    if (id_valid !== 1'b1) begin errs++; $display("FAIL wrap_id_valid: got %b, expected 1", id_valid); end
    if (id_params[63:32] !== 32'h0) begin errs++; $display("FAIL wrap_ia_plus_4: got %h, expected 00000000", id_params[63:32]); end
    if (id_params[31:0] !== mem_word(32'hFFFF_FFFC)) begin errs++; $display("FAIL wrap_ir: got %h, expected %h", id_params[31:0], mem_word(32'hFFFF_FFFC)); end
    if (imem_addr !== 32'h0) begin errs++; $display("FAIL wrap_next_addr: got %h, expected 00000000", imem_addr); end
  endtask
  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h1002;
    cycle();
    redirect_valid = 1'b0;
    #1;
    vecs += 2;
    if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL misalign_req_valid: got %b, expected 1", imem_req_valid); end
    if (imem_addr !== 32'h1000) begin errs++; $display("FAIL misalign_req_addr: got %h, expected 00001000", imem_addr); end
`ifdef FETCH_MISALIGN_CHECK_EN
    vecs++;
    if (fetch_misalign !== 1'b1) begin errs++; $display("FAIL misalign_flag_set: got %b, expected 1", fetch_misalign); end
`endif
    cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
    #1;
    vecs++;
    if (fetch_misalign !== 1'b0) begin errs++; $display("FAIL misalign_flag_clear: got %b, expected 0", fetch_misalign); end
`endif
  endtask
  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h3000;
    cycle();
    redirect_addr  = 32'h5004;
    cycle();
    redirect_valid = 1'b0;
    #1;
    vecs += 2;
    if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL b2b_req_valid: got %b, expected 1", imem_req_valid); end
    if (imem_addr !== 32'h5004) begin errs++; $display("FAIL b2b_req_addr: got %h, expected 00005004", imem_addr); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall          = $urandom_range(0, 3) == 0;
      imem_req_ready = $urandom_range(0, 2) != 0;
      lat            = $urandom_range(1, 3);
      redirect_valid = $urandom_range(0, 15) == 0;
      redirect_addr  = $urandom;
      cycle();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (10) cycle();
    vecs++;
    if (sb.size() > 1) begin errs++; $display("FAIL random_backlog: got %0d queued, expected at most 1", sb.size()); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
